exe_stage_md: RTL

//  Parametrised execute stage: N-source operand forwarding, integer ALU, branch/jump resolution

---
 rtl/exe_pkg.sv | 28 ++
 rtl/muldiv_iter.sv | 96 +++++++++
 rtl/exe_stage_md.sv | 132 +++++++++++++
 3 files changed

// File: rtl/exe_pkg.sv
// exe_pkg: shared types and helpers for the execute stage
package exe_pkg;
    localparam int XLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        OC_ALU, OC_BR, OC_JAL, OC_JALR, OC_MD, OC_LD, OC_ST
    } op_class_e;

    // ALU ops occupy 0..9; branch compares share the same field at 10..15
    typedef enum logic [3:0] {
        AC_ADD, AC_SUB, AC_SLL, AC_SLT, AC_SLTU, AC_XOR, AC_SRL, AC_SRA, AC_OR, AC_AND,
        AC_BEQ, AC_BNE, AC_BLT, AC_BGE, AC_BLTU, AC_BGEU
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
    } md_op_e;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} md_state_e;

    function automatic logic a_signed(input md_op_e op);
        return op inside {MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
    endfunction

    function automatic logic b_signed(input md_op_e op);
        return op inside {MD_MULH, MD_DIV, MD_REM};
    endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide unit with start/kill/busy/done handshake
//  start  : request in IDLE (already qualified by valid/class upstream)
//  kill   : abort, back to IDLE next edge; masks busy/done immediately
//  op,a,b : M-ext funct3 and operands, latched on acceptance
//  busy   : stall request (acceptance cycle plus every MUL/DIV cycle)
//  done   : result valid (DONE state), result is zero otherwise
module muldiv_iter
    import exe_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int DIV_STEP = 1,
    parameter int MUL_CYC  = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            kill,
    input  md_op_e          op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN / DIV_STEP + MUL_CYC + 1);
    md_state_e state, state_nx;
    md_op_e op_q;
    logic [CW-1:0] cnt;
    logic [XLEN-1:0] a_q, b_q, quo, rem, quo_nx, rem_nx, mag_a, mag_b, q_fix, r_fix, mul_res;
    logic [2*XLEN-1:0] xa, xb, prod;
    logic [XLEN:0] t;
    logic accept;

    assign accept = state == S_IDLE && start && !kill;
    assign mag_a  = (a_signed(op) && a[XLEN-1]) ? -a : a;
    assign mag_b  = (b_signed(op_q) && b_q[XLEN-1]) ? -b_q : b_q;

    // restoring division on magnitudes, DIV_STEP quotient bits per cycle
    always_comb begin
        rem_nx = rem;
        quo_nx = quo;
        t      = '0;
        for (int i = 0; i < DIV_STEP; i++) begin
            t      = {rem_nx, quo_nx[XLEN-1]};
            quo_nx = {quo_nx[XLEN-2:0], t >= {1'b0, mag_b}};
            t      = quo_nx[0] ? t - {1'b0, mag_b} : t;
            rem_nx = t[XLEN-1:0];
        end
    end

    always_comb begin
        state_nx = kill ? S_IDLE
                 : state == S_IDLE ? (start ? (op[2] ? S_DIV : S_MUL) : S_IDLE)
                 : state == S_DONE ? S_IDLE
                 : cnt == '0 ? S_DONE : state;
        busy = ~kill & (state == S_IDLE ? start : state != S_DONE);
        done = ~kill & state == S_DONE;
    end

    // special cases are applied only here so latency never depends on operands
    always_comb begin
        xa      = {{XLEN{a_signed(op_q) & a_q[XLEN-1]}}, a_q};
        xb      = {{XLEN{b_signed(op_q) & b_q[XLEN-1]}}, b_q};
        prod    = xa * xb;
        mul_res = op_q == MD_MUL ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
        q_fix   = b_q == '0 ? '1 : (a_signed(op_q) & (a_q[XLEN-1] ^ b_q[XLEN-1])) ? -quo : quo;
        r_fix   = b_q == '0 ? a_q : (a_signed(op_q) & a_q[XLEN-1]) ? -rem : rem;
        result  = !done ? '0 : !op_q[2] ? mul_res : op_q[1] ? r_fix : q_fix;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            op_q  <= MD_MUL;
            cnt   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            quo   <= '0;
            rem   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q <= op;
                a_q  <= a;
                b_q  <= b;
                quo  <= mag_a;
                rem  <= '0;
                cnt  <= op[2] ? CW'(XLEN / DIV_STEP - 1) : CW'(MUL_CYC - 1);
            end else if (state == S_MUL || state == S_DIV) begin
                cnt <= cnt - 1'b1;
                quo <= state == S_DIV ? quo_nx : quo;
                rem <= state == S_DIV ? rem_nx : rem;
            end
        end
    end
endmodule

// File: rtl/exe_stage_md.sv
// exe_stage_md: execute stage with forwarding, ALU, branch resolution and iterative mul/div
//  e_*            : ID/EX instruction fields and register-file data
//  fwd_*          : forwarding sources, index 0 youngest
//  e_result/e_store_data/result_valid : to EX/MEM
//  busy           : stall upstream while a mul/div is being accepted or iterated
//  redirect_*     : mispredict flush and correct fetch PC
//  bp_*           : predictor update for control-flow instructions
module exe_stage_md
    import exe_pkg::*;
#(
    parameter int XLEN     = XLEN_DEFAULT,
    parameter int NUM_FWD  = 2,
    parameter int DIV_STEP = 1,
    parameter int MUL_CYC  = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    e_valid,
    input  logic                    kill,
    input  logic [XLEN-1:0]         e_pc,
    input  logic [XLEN-1:0]         e_imm,
    input  logic [4:0]              e_rs1,
    input  logic [4:0]              e_rs2,
    input  logic [XLEN-1:0]         e_rs1_data,
    input  logic [XLEN-1:0]         e_rs2_data,
    input  logic [NUM_FWD-1:0]      fwd_we,
    input  logic [NUM_FWD*5-1:0]    fwd_rd,
    input  logic [NUM_FWD*XLEN-1:0] fwd_data,
    input  logic [2:0]              e_class,
    input  logic [3:0]              e_alu_ctrl,
    input  logic [2:0]              e_md_op,
    input  logic                    e_op1_sel,
    input  logic                    e_op2_sel,
    input  logic                    e_pred_taken,
    input  logic                    e_btb_hit,
    input  logic [XLEN-1:0]         e_btb_target,
    output logic [XLEN-1:0]         e_result,
    output logic [XLEN-1:0]         e_store_data,
    output logic                    result_valid,
    output logic                    busy,
    output logic                    redirect_valid,
    output logic [XLEN-1:0]         redirect_pc,
    output logic                    bp_update_en,
    output logic                    bp_taken,
    output logic [XLEN-1:0]         bp_pc,
    output logic [XLEN-1:0]         bp_target
);
    localparam int SW = $clog2(XLEN);
    op_class_e cls;
    alu_ctrl_e ctrl;
    logic [XLEN-1:0] rs1_v, rs2_v, op1, op2, alu_res, pc4, target, md_res;
    logic fire, is_md, is_jmp, is_cf, cmp, taken, dir_err, tgt_err, md_done;

    assign cls  = op_class_e'(e_class);
    assign ctrl = alu_ctrl_e'(e_alu_ctrl);

    // highest index first so the youngest matching source overwrites older ones
    always_comb begin
        rs1_v = e_rs1_data;
        rs2_v = e_rs2_data;
        for (int i = NUM_FWD - 1; i >= 0; i--) begin
            rs1_v = (fwd_we[i] && fwd_rd[i*5 +: 5] == e_rs1) ? fwd_data[i*XLEN +: XLEN] : rs1_v;
            rs2_v = (fwd_we[i] && fwd_rd[i*5 +: 5] == e_rs2) ? fwd_data[i*XLEN +: XLEN] : rs2_v;
        end
        rs1_v = e_rs1 == '0 ? '0 : rs1_v;
        rs2_v = e_rs2 == '0 ? '0 : rs2_v;
    end

    assign op1 = e_op1_sel ? e_pc : rs1_v;
    assign op2 = e_op2_sel ? e_imm : rs2_v;

    always_comb begin
        alu_res = '0;
        case (ctrl)
            AC_ADD:  alu_res = op1 + op2;
            AC_SUB:  alu_res = op1 - op2;
            AC_SLL:  alu_res = op1 << op2[SW-1:0];
            AC_SLT:  alu_res = XLEN'($signed(op1) < $signed(op2));
            AC_SLTU: alu_res = XLEN'(op1 < op2);
            AC_XOR:  alu_res = op1 ^ op2;
            AC_SRL:  alu_res = op1 >> op2[SW-1:0];
            AC_SRA:  alu_res = $signed(op1) >>> op2[SW-1:0];
            AC_OR:   alu_res = op1 | op2;
            AC_AND:  alu_res = op1 & op2;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        cmp = ctrl == AC_BEQ  ?  (rs1_v == rs2_v)
            : ctrl == AC_BNE  ?  (rs1_v != rs2_v)
            : ctrl == AC_BLT  ?  ($signed(rs1_v) < $signed(rs2_v))
            : ctrl == AC_BGE  ? !($signed(rs1_v) < $signed(rs2_v))
            : ctrl == AC_BLTU ?  (rs1_v < rs2_v)
            : ctrl == AC_BGEU ? !(rs1_v < rs2_v) : 1'b0;
        fire    = e_valid & ~kill;
        is_md   = cls == OC_MD;
        is_jmp  = cls == OC_JAL || cls == OC_JALR;
        is_cf   = is_jmp || cls == OC_BR;
        taken   = is_jmp | (cls == OC_BR & cmp);
        pc4     = e_pc + XLEN'(4);
        target  = cls == OC_JALR ? (rs1_v + e_imm) & ~XLEN'(1) : e_pc + e_imm;
        // predicted-taken without a BTB hit never left the sequential path
        dir_err = (taken != e_pred_taken) & ~(e_pred_taken & ~e_btb_hit & ~taken);
        tgt_err = taken & e_pred_taken & (~e_btb_hit | e_btb_target != target);
    end

    muldiv_iter #(.XLEN(XLEN), .DIV_STEP(DIV_STEP), .MUL_CYC(MUL_CYC)) u_md (
        .clk    (clk),
        .rst    (rst),
        .start  (fire & is_md),
        .kill   (kill),
        .op     (md_op_e'(e_md_op)),
        .a      (rs1_v),
        .b      (rs2_v),
        .busy   (busy),
        .done   (md_done),
        .result (md_res)
    );

    always_comb begin
        result_valid   = md_done | (fire & ~is_md);
        e_result       = md_done ? md_res : (fire & ~is_md) ? (is_jmp ? pc4 : alu_res) : '0;
        e_store_data   = e_valid ? rs2_v : '0;
        redirect_valid = fire & (dir_err | tgt_err);
        redirect_pc    = redirect_valid ? (taken ? target : pc4) : '0;
        bp_update_en   = fire & is_cf;
        bp_taken       = bp_update_en & taken;
        bp_pc          = bp_update_en ? e_pc : '0;
        bp_target      = bp_update_en ? target : '0;
    end
endmodule
